ex_mul_div_unit: RTL

- Iterative RV64M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts one M-extension op from ID_EX and latches its operands.
- Computes the result over multiple cycles and asserts a stall request into the pipeline control block (its alu_mul_div_valid_ex_i input) until the result is ready.
- Presents a registered result for one cycle so it enters EX_MEM; a trap flush aborts any in-flight operation.

---
 rtl/ex_mul_div_unit_if.sv | 25 ++
 rtl/ex_mul_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_div_unit_if.sv
// EX-stage M-extension unit port bundle.
// Master drives the op, slave returns stall and result.
interface ex_mul_div_unit_if #(
  parameter int XLEN = 64
);
  logic            valid_i;
  logic [3:0]      op_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            flush_i;
  logic            stall_req_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, src1_i, src2_i, flush_i,
    input  stall_req_o, busy_o, result_valid_o, result_o
  );

  modport slave (
    input  valid_i, op_i, src1_i, src2_i, flush_i,
    output stall_req_o, busy_o, result_valid_o, result_o
  );
endinterface

// File: rtl/ex_mul_div_unit.sv
// Iterative RV64M multiply/divide unit beside the EX ALU.
// Shift-add multiply, restoring divide, one bit per cycle.
module ex_mul_div_unit #(
  parameter int XLEN = 64
) (
  input  logic clk,
  input  logic rst_n,
  ex_mul_div_unit_if.slave io
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic f_div(input logic [3:0] op);
    return op inside {4'd4, 4'd5, 4'd6, 4'd7,
                      4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  function automatic logic f_rem(input logic [3:0] op);
    return op inside {4'd6, 4'd7, 4'd11, 4'd12};
  endfunction

  function automatic logic f_w(input logic [3:0] op);
    return op inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  function automatic logic f_mulh(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3};
  endfunction

  // src1 is signed for every signed op, MULHSU included
  function automatic logic f_s1(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4,
                      4'd6, 4'd8, 4'd9, 4'd11};
  endfunction

  function automatic logic f_s2(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd4, 4'd6,
                      4'd8, 4'd9, 4'd11};
  endfunction

  function automatic logic [XLEN-1:0] sx32(
    input logic [31:0] x
  );
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  logic                in_div, in_rem, in_w;
  logic                in_s1, in_s2;
  logic [XLEN-1:0]     ext1, ext2;
  logic                in_neg1, in_neg2;
  logic [XLEN-1:0]     abs1, abs2;
  logic [XLEN-1:0]     minv;
  logic                dz, ovf, fast;
  logic                accept;
  logic [XLEN-1:0]     fast_raw, fast_res;
  logic [XLEN-1:0]     lo_init;

  logic                q_div, q_rem, q_w, q_mulh;
  logic [XLEN-1:0]     hi, lo;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt;
  logic [XLEN:0]       div_r, div_sub;
  logic                div_ge;
  logic [XLEN-1:0]     div_rn;
  logic [2*XLEN-1:0]   div_nxt;
  logic [2*XLEN-1:0]   prod, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;
  logic [XLEN-1:0]     raw, fin;

  // Decode the incoming op and its fast-path cases
  always_comb begin
    in_div  = f_div(io.op_i);
    in_rem  = f_rem(io.op_i);
    in_w    = f_w(io.op_i);
    in_s1   = f_s1(io.op_i);
    in_s2   = f_s2(io.op_i);
    ext1    = io.src1_i;
    ext2    = io.src2_i;
    if (in_w) begin
      ext1 = {{(XLEN-32){in_s1 & io.src1_i[31]}},
              io.src1_i[31:0]};
      ext2 = {{(XLEN-32){in_s2 & io.src2_i[31]}},
              io.src2_i[31:0]};
    end
    in_neg1 = in_s1 & ext1[XLEN-1];
    in_neg2 = in_s2 & ext2[XLEN-1];
    abs1    = in_neg1 ? (~ext1 + 1'b1) : ext1;
    abs2    = in_neg2 ? (~ext2 + 1'b1) : ext2;
    minv    = in_w ? {{(XLEN-31){1'b1}}, 31'b0}
                   : {1'b1, {(XLEN-1){1'b0}}};
    dz      = in_div & (ext2 == '0);
    ovf     = in_div & in_s2 & (ext1 == minv)
            & (ext2 == '1);
    fast    = dz | ovf;
    accept  = (state_q == IDLE) & io.valid_i
            & ~io.flush_i & (io.op_i <= 4'd12);
    if (dz) begin
      fast_raw = in_rem ? ext1 : '1;
    end else begin
      fast_raw = in_rem ? '0 : ext1;
    end
    fast_res = in_w ? sx32(fast_raw[31:0]) : fast_raw;
    lo_init  = (in_w & in_div) ? (abs1 << 32) : abs1;
  end

  // One iteration step plus sign fix-up of the latched op
  always_comb begin
    q_div   = f_div(op_q);
    q_rem   = f_rem(op_q);
    q_w     = f_w(op_q);
    q_mulh  = f_mulh(op_q);
    hi      = acc_q[2*XLEN-1:XLEN];
    lo      = acc_q[XLEN-1:0];
    mul_sum = {1'b0, hi}
            + (lo[0] ? {1'b0, b_q} : '0);
    mul_nxt = {mul_sum, lo[XLEN-1:1]};
    div_r   = {hi, lo[XLEN-1]};
    div_sub = div_r - {1'b0, b_q};
    div_ge  = ~div_sub[XLEN];
    div_rn  = div_ge ? div_sub[XLEN-1:0]
                     : div_r[XLEN-1:0];
    div_nxt = {div_rn, lo[XLEN-2:0], div_ge};
    prod    = q_w ? (mul_nxt >> 32) : mul_nxt;
    prod_s  = (neg1_q ^ neg2_q) ? (~prod + 1'b1) : prod;
    quo_s   = (neg1_q ^ neg2_q)
            ? (~div_nxt[XLEN-1:0] + 1'b1)
            : div_nxt[XLEN-1:0];
    rem_s   = neg1_q
            ? (~div_nxt[2*XLEN-1:XLEN] + 1'b1)
            : div_nxt[2*XLEN-1:XLEN];
    raw     = prod_s[XLEN-1:0];
    unique case (1'b1)
      q_div & q_rem:  raw = rem_s;
      q_div & ~q_rem: raw = quo_s;
      q_mulh:         raw = prod_s[2*XLEN-1:XLEN];
      default:        raw = prod_s[XLEN-1:0];
    endcase
    fin = q_w ? sx32(raw[31:0]) : raw;
  end

  // Datapath and counter next-state
  always_comb begin
    op_d   = op_q;
    neg1_d = neg1_q;
    neg2_d = neg2_q;
    b_d    = b_q;
    acc_d  = acc_q;
    res_d  = res_q;
    cnt_d  = '0;
    if (accept) begin
      op_d   = io.op_i;
      neg1_d = in_neg1;
      neg2_d = in_neg2;
      b_d    = abs2;
      acc_d  = {{XLEN{1'b0}}, lo_init};
      if (fast) begin
        res_d = fast_res;
      end else begin
        cnt_d = in_w ? CW'(31) : CW'(XLEN-1);
      end
    end else if (state_q == CALC && !io.flush_i) begin
      acc_d = q_div ? div_nxt : mul_nxt;
      if (cnt_q == '0) begin
        res_d = fin;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      neg1_q <= neg1_d;
      neg2_q <= neg2_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush_i) state_d = IDLE;
  end

  // FSM outputs; DONE releases the stall so EX_MEM takes the result
  always_comb begin
    io.stall_req_o    = ((state_q == IDLE) & accept)
                      | (state_q == CALC);
    io.busy_o         = (state_q != IDLE);
    io.result_valid_o = (state_q == DONE) & ~io.flush_i;
    io.result_o       = res_q;
  end

endmodule
